// File: rtl/h_bridge_pwm_driver.sv
// H-bridge output stage: turns router IN-pin decisions into IN1..IN4 and ENA/ENB drive, with dead time, shoot-through blocking and soft-start PWM.
// Latency: one clock from a sampled command to the registered pins; every exit from driving holds all pins low for DEAD_CYCLES clocks.
// Backpressure: none. Inputs are sampled every cycle; commands that arrive during dead time are only acted on once the blanking has finished.
module h_bridge_pwm_driver #(
    parameter int PWM_WIDTH   = 8,
    parameter int DEAD_CYCLES = 5000,
    parameter int RAMP_DIV    = 10000,
    parameter int RAMP_STEP   = 16
) (
    input  logic                 clock,
    input  logic                 reset_n,
    input  logic                 enable,
    input  logic [3:0]           movingDirection_finalDecision,
    input  logic [PWM_WIDTH-1:0] speed_duty,
    output logic [3:0]           H_BridgeIN,
    output logic [1:0]           H_BridgeEN,
    output logic                 driving,
    output logic                 deadTimeBusy,
    output logic                 illegalCmd
);

    // Counter widths are sized so that the largest loaded value fits; both are at least 1 bit.
    localparam int DW = (DEAD_CYCLES > 1) ? $clog2(DEAD_CYCLES) : 1;
    localparam int RW = (RAMP_DIV > 1) ? $clog2(RAMP_DIV) : 1;

    localparam logic [DW-1:0]        DEAD_LOAD = DW'(DEAD_CYCLES - 1);
    localparam logic [RW-1:0]        RAMP_LAST = RW'(RAMP_DIV - 1);
    localparam logic [PWM_WIDTH:0]   STEP_EXT  = (PWM_WIDTH + 1)'(RAMP_STEP);

    typedef enum logic [1:0] {
        ST_STOP = 2'd0,
        ST_RUN  = 2'd1,
        ST_DEAD = 2'd2
    } state_t;

    state_t               state;
    logic [3:0]           active_cmd;
    logic [PWM_WIDTH-1:0] duty_cur;
    logic [PWM_WIDTH-1:0] pwm_cnt;
    logic [DW-1:0]        dead_cnt;
    logic [RW-1:0]        ramp_cnt;

    logic                 cmd_legal;
    logic                 cmd_drive;
    logic                 start_ok;
    logic                 keep_run;
    logic                 go_run;
    logic                 ramp_tick;
    logic [PWM_WIDTH:0]   duty_sum;
    logic [PWM_WIDTH-1:0] duty_ramped;
    logic [PWM_WIDTH-1:0] duty_next;
    logic                 pwm_on;

    // Command classification, run/exit decisions and the next ramped duty value.
    always_comb begin
        cmd_legal   = (movingDirection_finalDecision[1:0] != 2'b11) &&
                      (movingDirection_finalDecision[3:2] != 2'b11);
        cmd_drive   = cmd_legal && (movingDirection_finalDecision != 4'b0000);
        start_ok    = enable && cmd_drive;
        // active_cmd is always a drive command while running, so equality alone
        // rules out zero, illegal and different-direction commands.
        keep_run    = enable && (movingDirection_finalDecision == active_cmd);
        go_run      = start_ok &&
                      ((state == ST_STOP) ||
                       ((state == ST_DEAD) && (dead_cnt == '0)));
        ramp_tick   = (ramp_cnt == RAMP_LAST);
        // One extra bit keeps the step from wrapping past full scale.
        duty_sum    = {1'b0, duty_cur} + STEP_EXT;
        duty_ramped = (duty_sum > {1'b0, speed_duty}) ? speed_duty
                                                      : duty_sum[PWM_WIDTH-1:0];
        duty_next   = duty_cur;
        if (speed_duty < duty_cur) begin
            // A lowered target takes effect at once; only increases are ramped.
            duty_next = speed_duty;
        end else if (ramp_tick) begin
            duty_next = duty_ramped;
        end
        pwm_on      = (pwm_cnt < duty_cur);
    end

    // Free-running PWM carrier; it keeps counting in every state.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            pwm_cnt <= '0;
        end else begin
            pwm_cnt <= pwm_cnt + 1'b1;
        end
    end

    // Illegal-command flag, re-evaluated every cycle regardless of state.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            illegalCmd <= 1'b0;
        end else begin
            illegalCmd <= !cmd_legal;
        end
    end

    // Bridge control FSM: STOP -> RUN on a drive command, RUN -> DEAD on any exit, DEAD -> RUN/STOP once blanking is complete.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state        <= ST_STOP;
            active_cmd   <= 4'b0000;
            duty_cur     <= '0;
            dead_cnt     <= '0;
            ramp_cnt     <= '0;
            H_BridgeIN   <= 4'b0000;
            H_BridgeEN   <= 2'b00;
            driving      <= 1'b0;
            deadTimeBusy <= 1'b0;
        end else if (go_run) begin
            // Entry into RUN: latch the command and restart the soft-start ramp from zero.
            state        <= ST_RUN;
            active_cmd   <= movingDirection_finalDecision;
            duty_cur     <= '0;
            ramp_cnt     <= '0;
            H_BridgeIN   <= movingDirection_finalDecision;
            H_BridgeEN   <= 2'b00;
            driving      <= 1'b1;
            deadTimeBusy <= 1'b0;
        end else begin
            unique case (state)
                ST_RUN: begin
                    if (keep_run) begin
                        H_BridgeIN <= active_cmd;
                        H_BridgeEN <= {2{pwm_on}};
                        duty_cur   <= duty_next;
                        ramp_cnt   <= ramp_tick ? '0 : ramp_cnt + RW'(1);
                    end else begin
                        // Any exit blanks the bridge at this same edge.
                        state        <= ST_DEAD;
                        dead_cnt     <= DEAD_LOAD;
                        H_BridgeIN   <= 4'b0000;
                        H_BridgeEN   <= 2'b00;
                        driving      <= 1'b0;
                        deadTimeBusy <= 1'b1;
                    end
                end
                ST_DEAD: begin
                    H_BridgeIN <= 4'b0000;
                    H_BridgeEN <= 2'b00;
                    if (dead_cnt == '0) begin
                        // Blanking finished and no new drive request: park in STOP.
                        state        <= ST_STOP;
                        deadTimeBusy <= 1'b0;
                    end else begin
                        dead_cnt <= dead_cnt - DW'(1);
                    end
                end
                default: begin
                    state        <= ST_STOP;
                    H_BridgeIN   <= 4'b0000;
                    H_BridgeEN   <= 2'b00;
                    driving      <= 1'b0;
                    deadTimeBusy <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_h_bridge_pwm_driver.sv
// Bench for h_bridge_pwm_driver: directed scenarios followed by random command traffic.
// Each cycle's outputs are compared with a behavioural model of the bridge rules.
// The model tracks "who is driving", "blank cycles left", duty and the phases using plain integer arithmetic.
module tb_h_bridge_pwm_driver;

    localparam int PW    = 8;
    localparam int DEAD  = 4;
    localparam int RDIV  = 2;
    localparam int STEP  = 64;

    logic          clock;
    logic          reset_n;
    logic          enable;
    logic [3:0]    cmd;
    logic [PW-1:0] speed;
    logic [3:0]    h_in;
    logic [1:0]    h_en;
    logic          drv;
    logic          busy;
    logic          ill;

    int n_vec = 0;
    int n_err = 0;

    // Reference model state.
    int m_cmd, m_dead, m_duty, m_ramp, m_pwm, m_en, m_ill;
    bit m_drv;

    h_bridge_pwm_driver #(
        .PWM_WIDTH  (PW),
        .DEAD_CYCLES(DEAD),
        .RAMP_DIV   (RDIV),
        .RAMP_STEP  (STEP)
    ) dut (
        .clock                        (clock),
        .reset_n                      (reset_n),
        .enable                       (enable),
        .movingDirection_finalDecision(cmd),
        .speed_duty                   (speed),
        .H_BridgeIN                   (h_in),
        .H_BridgeEN                   (h_en),
        .driving                      (drv),
        .deadTimeBusy                 (busy),
        .illegalCmd                   (ill)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check_val(input string tag, input int obs, input int exp);
        n_vec++;
        if (obs != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_cmd = 0; m_dead = 0; m_duty = 0; m_ramp = 0; m_pwm = 0;
        m_en = 0; m_ill = 0; m_drv = 0;
    endtask

    // One rising edge of the bridge rules, given the inputs present at that edge.
    task automatic model_step(input bit e, input int c, input int sd);
        bit legal, drive_cmd, tick;
        int en_out;
        legal     = ((c & 3) != 3) && (((c >> 2) & 3) != 3);
        drive_cmd = legal && (c != 0);
        en_out    = 0;
        if (m_drv) begin
            if (e && c == m_cmd) begin
                en_out = (m_pwm < m_duty) ? 3 : 0;
                tick   = (m_ramp == RDIV - 1);
                m_ramp = (m_ramp + 1) % RDIV;
                if (sd < m_duty)  m_duty = sd;
                else if (tick)    m_duty = (m_duty + STEP > sd) ? sd : m_duty + STEP;
            end else begin
                m_drv  = 0;
                m_dead = DEAD;
            end
        end else if (m_dead > 1) begin
            m_dead--;
        end else begin
            // Either idle, or this edge closes the final blank cycle.
            m_dead = 0;
            if (e && drive_cmd) begin
                m_drv = 1; m_cmd = c; m_duty = 0; m_ramp = 0;
            end
        end
        m_ill = legal ? 0 : 1;
        m_pwm = (m_pwm + 1) % (1 << PW);
        m_en  = en_out;
    endtask

    task automatic compare_outputs();
        check_val("H_BridgeIN",   int'(h_in), m_drv ? m_cmd : 0);
        check_val("H_BridgeEN",   int'(h_en), m_en);
        check_val("driving",      int'(drv),  int'(m_drv));
        check_val("deadTimeBusy", int'(busy), (m_dead > 0) ? 1 : 0);
        check_val("illegalCmd",   int'(ill),  m_ill);
    endtask

    // Apply inputs for one cycle, clock it, then compare just after the edge.
    task automatic cyc(input bit e, input logic [3:0] c, input int sd);
        enable = e;
        cmd    = c;
        speed  = PW'(sd);
        @(posedge clock);
        model_step(e, int'(c), sd);
        #1;
        compare_outputs();
    endtask

    // Reset pulse placed between edges; outputs must clear without waiting for a clock.
    task automatic async_reset_pulse();
        #2 reset_n = 1'b0;
        #1;
        check_val("async_rst_IN",   int'(h_in), 0);
        check_val("async_rst_EN",   int'(h_en), 0);
        check_val("async_rst_drv",  int'(drv),  0);
        check_val("async_rst_busy", int'(busy), 0);
        model_reset();
        #1 reset_n = 1'b1;
    endtask

    initial begin
        int highs;
        logic [3:0] cmds [8];
        logic [3:0] rc;
        bit re;
        int rs;
        cmds = '{4'b0110, 4'b1001, 4'b0101, 4'b1010, 4'b0000, 4'b0111, 4'b1100, 4'b0010};

        reset_n = 1'b0;
        enable  = 1'b0;
        cmd     = 4'b0000;
        speed   = '0;
        model_reset();
        repeat (3) @(posedge clock);
        #1;
        compare_outputs();
        reset_n = 1'b1;

        // Start forward at duty 200 and let the ramp settle.
        repeat (12) cyc(1'b1, 4'b0110, 200);
        highs = 0;
        for (int i = 0; i < 256; i++) begin
            cyc(1'b1, 4'b0110, 200);
            if (h_en == 2'b11) highs++;
        end
        check_val("en_high_of_256_at_200", highs, 200);

        // Direction reversal: dead time, then restart with a fresh ramp.
        repeat (12) cyc(1'b1, 4'b1001, 200);

        // Illegal command while running, held through the dead time.
        repeat (8) cyc(1'b1, 4'b0111, 200);
        check_val("stop_after_illegal_drv",  int'(drv),  0);
        check_val("stop_after_illegal_busy", int'(busy), 0);

        // enable drops for one cycle during dead time while the command stays put.
        repeat (6) cyc(1'b1, 4'b1001, 200);
        cyc(1'b0, 4'b1001, 200);
        cyc(1'b1, 4'b1001, 200);
        cyc(1'b0, 4'b1001, 200);
        repeat (10) cyc(1'b1, 4'b1001, 200);

        // Target lowered, then zeroed while still driving.
        cyc(1'b1, 4'b1001, 50);
        repeat (10) cyc(1'b1, 4'b1001, 50);
        highs = 0;
        for (int i = 0; i < 256; i++) begin
            cyc(1'b1, 4'b1001, 0);
            if (h_en != 2'b00) highs++;
        end
        check_val("en_high_at_duty0", highs, 0);
        check_val("in_held_at_duty0", int'(h_in), 4'b1001);

        // Asynchronous reset mid-run, then immediate restart without dead time.
        repeat (4) cyc(1'b1, 4'b0110, 120);
        async_reset_pulse();
        cyc(1'b1, 4'b0110, 120);
        check_val("restart_after_reset", int'(h_in), 4'b0110);
        repeat (6) cyc(1'b1, 4'b0110, 120);

        // Random traffic.
        rc = 4'b0110;
        re = 1'b1;
        rs = 180;
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 9) == 0) rc = cmds[$urandom_range(0, 7)];
            re = ($urandom_range(0, 15) != 0);
            if ($urandom_range(0, 49) == 0) rs = $urandom_range(0, 255);
            cyc(re, rc, rs);
            if ($urandom_range(0, 499) == 0) async_reset_pulse();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
